cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 mfc0  input  1  decoded MFC0; read request for register addr.
REQ-004 mtc0  input  1  decoded MTC0; write data into register addr.
REQ-005 eret  input  1  decoded ERET.
REQ-006 exception  input  1  decoded trap request; may be high together with eret.
REQ-007 cause  input  5  ExcCode of trap: 8 syscall, 9 break, 13 teq.
REQ-008 addr  input  5  CP0 register number (rd field).
REQ-009 wdata  input  32  rt value for MTC0.
REQ-010 pc  input  32  address of the current instruction.
REQ-011 rdata  output  32  MFC0 read data.
REQ-012 status  output  32  current Status register.
REQ-013 exc_taken  output  1  PC must load exc_addr this cycle.
REQ-014 exc_addr  output  32  trap vector, or EPC on ERET.
REQ-015 timer_irq  output  1  timer interrupt pending and enabled.

Function
REQ-016 Implemented registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14); all 32 bits.
REQ-017 Status[0] is global enable; Status[1], [2] and [3] enable syscall, break and teq.
REQ-018 A trap is accepted when exception=1, eret=0, Status[0]=1 and the mask bit for cause is 1; other ExcCodes are never accepted.
REQ-019 eret=1 takes priority over exception=1 and is always accepted.
REQ-020 exc_taken = eret | accepted trap; combinational, same cycle as the inputs.
REQ-021 exc_addr = EPC when eret=1, else 32'h0040_0004; it is valid whenever exc_taken=1.
REQ-022 On an accepted trap, next edge: EPC<=pc; Cause[6:2]<=cause; Status<={Status[26:0],5'b0}.
REQ-023 On eret, next edge: Status<={5'b0,Status[31:5]}; EPC and Cause are unchanged.
REQ-024 A rejected trap changes no state and drives exc_taken=0.
REQ-025 mtc0 writes wdata to Status, EPC, Count or Compare on the next edge.
REQ-026 mtc0 to Cause writes bits [6:2] only; mtc0 to an unimplemented address is ignored.
REQ-027 Trap or eret update of Status, EPC or Cause overrides a same-cycle mtc0 to the same register.
REQ-028 rdata = the addressed register's pre-edge value while mfc0=1; 0 when mfc0=0 or address unimplemented.
REQ-029 Count increments by 1 every cycle and wraps 32'hFFFF_FFFF->0; a mtc0 Count write replaces the increment.
REQ-030 When Count==Compare and Compare!=0, Cause[15] is set on the next edge and stays set.
REQ-031 A mtc0 Compare write clears Cause[15]; if a match occurs in the same cycle, the clear wins.
REQ-032 timer_irq = Cause[15] & Status[0]; the unit never redirects the PC on its own.

Reset
REQ-033 While rst_n=0, registers take these values: Status=32'h0000_000F, Cause=0, EPC=0, Count=0, Compare=0.
REQ-034 While rst_n=0, outputs are: rdata=0, exc_taken=0, timer_irq=0 and exc_addr=32'h0040_0004.
REQ-035 Reset asserted mid-operation aborts any pending update; the first edge after release behaves as from reset state.

Structure
REQ-036 Shared package cp0_pkg holds:
- register numbers 9/11/12/13/14;
- ExcCodes 8/9/13;
- vector constant 32'h0040_0004;
- reset value 32'h0000_000F.
REQ-037 Count, Compare and the match logic form sub-module cp0_timer, which outputs the match pulse and Count/Compare values.

Verification
REQ-038 syscall trap: Status=0xF, pc=0x0040_0100, exception=1, cause=8 -> exc_taken=1, exc_addr=0x0040_0004; next edge EPC=0x0040_0100, Cause[6:2]=8, Status=0x1E0.
REQ-039 eret after the trap: eret=1, exception=1 -> exc_taken=1, exc_addr=0x0040_0100; next edge Status=0xF.
REQ-040 masked trap: Status=0xB, exception=1, cause=9 -> exc_taken=0; no register changes.
REQ-041 timer: mtc0 Compare=5 after reset -> Cause[15]=1 once Count reaches 5, timer_irq=1; mtc0 Compare=100 -> Cause[15]=0 on the next edge.
REQ-042 mfc0 read-during-write: mtc0 EPC=0x1234 and mfc0 EPC in the same cycle -> rdata=old EPC; next cycle rdata=0x1234.
REQ-043 reset mid-operation: rst_n=0 asserted during an accepted trap -> Status=0xF and EPC=0 immediately, with no trap update after release.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 unit: register numbers, trap codes, vector and reset values.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_SYSCALL = 5'd8,
        EXC_BREAK   = 5'd9,
        EXC_TEQ     = 5'd13
    } exc_code_e;

    localparam logic [31:0] EXC_VECTOR   = 32'h0040_0004;
    localparam logic [31:0] STATUS_RESET = 32'h0000_000F;

    // mask holds Status[3:1]: teq, break, syscall enables; unknown codes are never enabled
    function automatic logic trap_enabled(input logic [2:0] mask, input logic [4:0] code);
        logic en;
        en = 1'b0;
        case (code)
            EXC_SYSCALL: en = mask[0];
            EXC_BREAK:   en = mask[1];
            EXC_TEQ:     en = mask[2];
            default:     en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 connection: decoded requests in, read data and redirect out.
interface cp0_if;
    // mfc0/mtc0/eret/exception are single-cycle decoded strobes qualified by the same cycle's
    // addr/wdata/cause/pc; there is no backpressure, every strobe is consumed at the next edge.
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic        exception;
    logic [4:0]  cause;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] status;
    logic        exc_taken;
    logic [31:0] exc_addr;
    logic        timer_irq;

    modport master (
        output mfc0, mtc0, eret, exception, cause, addr, wdata, pc,
        input  rdata, status, exc_taken, exc_addr, timer_irq
    );

    modport slave (
        input  mfc0, mtc0, eret, exception, cause, addr, wdata, pc,
        output rdata, status, exc_taken, exc_addr, timer_irq
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare pair; match is asserted while Count equals a non-zero Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic        match,
    output logic [31:0] count,
    output logic [31:0] compare
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            compare <= '0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we) begin
                compare <= wdata;
            end
        end
    end

    assign match = (count == compare) && (compare != '0);

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC plus timer, trap acceptance and ERET return.
module cp0_unit
    import cp0_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    cp0_if.slave bus
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [4:0]  exc_code_q;
    logic        ti_q;
    logic [31:0] cause_val;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic        trap_ok;
    logic [31:0] rd_mux;

    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    assign wr_status  = bus.mtc0 && (bus.addr == REG_STATUS);
    assign wr_cause   = bus.mtc0 && (bus.addr == REG_CAUSE);
    assign wr_epc     = bus.mtc0 && (bus.addr == REG_EPC);
    assign wr_count   = bus.mtc0 && (bus.addr == REG_COUNT);
    assign wr_compare = bus.mtc0 && (bus.addr == REG_COMPARE);

    assign trap_ok = bus.exception && !bus.eret && status_q[0]
                     && trap_enabled(status_q[3:1], bus.cause);

    // Only the ExcCode field and the timer-pending bit exist in Cause
    assign cause_val = {16'b0, ti_q, 8'b0, exc_code_q, 2'b0};

    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (bus.wdata),
        .match      (match),
        .count      (count),
        .compare    (compare)
    );

    // Trap/ERET updates sit above mtc0 in each priority chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            exc_code_q <= '0;
            ti_q       <= 1'b0;
        end else begin
            if (bus.eret) begin
                status_q <= {5'b0, status_q[31:5]};
            end else if (trap_ok) begin
                status_q <= {status_q[26:0], 5'b0};
            end else if (wr_status) begin
                status_q <= bus.wdata;
            end

            if (trap_ok) begin
                epc_q <= bus.pc;
            end else if (wr_epc) begin
                epc_q <= bus.wdata;
            end

            if (trap_ok) begin
                exc_code_q <= bus.cause;
            end else if (wr_cause) begin
                exc_code_q <= bus.wdata[6:2];
            end

            if (wr_compare) begin
                ti_q <= 1'b0;
            end else if (match) begin
                ti_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_COUNT:   rd_mux = count;
            REG_COMPARE: rd_mux = compare;
            REG_STATUS:  rd_mux = status_q;
            REG_CAUSE:   rd_mux = cause_val;
            REG_EPC:     rd_mux = epc_q;
            default:     rd_mux = '0;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the strobes
    assign bus.rdata     = (rst_n && bus.mfc0) ? rd_mux : '0;
    assign bus.exc_taken = rst_n && (bus.eret || trap_ok);
    assign bus.exc_addr  = (rst_n && bus.eret) ? epc_q : EXC_VECTOR;
    assign bus.status    = status_q;
    assign bus.timer_irq = ti_q && status_q[0];

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with a cycle-tagged expectation queue checked by a monitor.
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam int S_RDATA  = 0;
    localparam int S_TAKEN  = 1;
    localparam int S_EADDR  = 2;
    localparam int S_STATUS = 3;
    localparam int S_TIRQ   = 4;

    typedef struct {
        int    cyc;
        int    sel;
        string name;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] exp_q[$];
    chk_t        tag_q[$];

    cp0_if bus();

    cp0_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    // driver tasks
    task automatic idle();
        bus.mfc0      = 1'b0;
        bus.mtc0      = 1'b0;
        bus.eret      = 1'b0;
        bus.exception = 1'b0;
        bus.cause     = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.pc        = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a);
        bus.mfc0 = 1'b1;
        bus.addr = a;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0  = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic trap(input logic [4:0] c, input logic [31:0] p);
        bus.exception = 1'b1;
        bus.cause     = c;
        bus.pc        = p;
    endtask

    task automatic chk(input int sel, input string name, input logic [31:0] v);
        chk_t t;
        t.cyc  = cyc_cnt;
        t.sel  = sel;
        t.name = name;
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    // scoreboard monitor: compares every expectation tagged for the current cycle
    always @(negedge clk) begin
        chk_t        t;
        logic [31:0] e;
        logic [31:0] a;
        while (tag_q.size() > 0 && tag_q[0].cyc <= cyc_cnt) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            case (t.sel)
                S_RDATA:  a = bus.rdata;
                S_TAKEN:  a = {31'b0, bus.exc_taken};
                S_EADDR:  a = bus.exc_addr;
                S_STATUS: a = bus.status;
                default:  a = {31'b0, bus.timer_irq};
            endcase
            n_checks++;
            if (t.cyc != cyc_cnt || a !== e) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", t.name, t.cyc, a, e);
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;

        // outputs quiet during reset even with strobes asserted
        next();
        bus.eret = 1'b1; trap(EXC_SYSCALL, 32'h0040_0100); rd(REG_STATUS);
        chk(S_RDATA, "rst_rdata", 32'h0);
        chk(S_TAKEN, "rst_taken", 32'h0);
        chk(S_EADDR, "rst_eaddr", EXC_VECTOR);
        chk(S_STATUS, "rst_status", 32'h0000_000F);
        chk(S_TIRQ, "rst_tirq", 32'h0);

        next(); rst_n = 1'b1; rd(REG_STATUS);
        chk(S_RDATA, "status_read", 32'h0000_000F);
        chk(S_TAKEN, "idle_taken", 32'h0);

        // accepted syscall
        next(); trap(EXC_SYSCALL, 32'h0040_0100); rd(REG_EPC);
        chk(S_TAKEN, "sys_taken", 32'h1);
        chk(S_EADDR, "sys_eaddr", 32'h0040_0004);
        chk(S_RDATA, "sys_epc_old", 32'h0);

        next(); rd(REG_EPC);
        chk(S_RDATA, "sys_epc", 32'h0040_0100);
        chk(S_STATUS, "sys_status", 32'h0000_01E0);
        chk(S_TAKEN, "sys_after_taken", 32'h0);

        next(); rd(REG_CAUSE);
        chk(S_RDATA, "sys_cause", 32'h0000_0020);

        // eret wins over simultaneous exception
        next(); bus.eret = 1'b1; trap(EXC_BREAK, 32'h0040_0180);
        chk(S_TAKEN, "eret_taken", 32'h1);
        chk(S_EADDR, "eret_eaddr", 32'h0040_0100);
        chk(S_STATUS, "eret_status_pre", 32'h0000_01E0);

        next(); rd(REG_CAUSE);
        chk(S_STATUS, "eret_status", 32'h0000_000F);
        chk(S_RDATA, "eret_cause_kept", 32'h0000_0020);

        // masked break
        next(); wr(REG_STATUS, 32'h0000_000B);
        next(); trap(EXC_BREAK, 32'h0040_0200); rd(REG_EPC);
        chk(S_STATUS, "mask_status", 32'h0000_000B);
        chk(S_TAKEN, "mask_taken", 32'h0);
        chk(S_EADDR, "mask_eaddr", EXC_VECTOR);
        chk(S_RDATA, "mask_epc", 32'h0040_0100);

        // teq still enabled under the same Status
        next(); rd(REG_CAUSE); trap(EXC_TEQ, 32'h0040_0200);
        chk(S_RDATA, "mask_cause", 32'h0000_0020);
        chk(S_STATUS, "mask_status_kept", 32'h0000_000B);
        chk(S_TAKEN, "teq_taken", 32'h1);

        next(); rd(REG_CAUSE);
        chk(S_RDATA, "teq_cause", 32'h0000_0034);
        chk(S_STATUS, "teq_status", 32'h0000_0160);

        // unknown ExcCode never accepted
        next(); wr(REG_STATUS, 32'h0000_000F);
        next(); trap(5'd4, 32'h0040_0280); rd(REG_EPC);
        chk(S_TAKEN, "badcode_taken", 32'h0);
        chk(S_RDATA, "badcode_epc", 32'h0040_0200);
        chk(S_STATUS, "badcode_status", 32'h0000_000F);

        // read during write
        next(); wr(REG_EPC, 32'h0000_1234); bus.mfc0 = 1'b1;
        chk(S_RDATA, "rdw_old", 32'h0040_0200);
        next(); rd(REG_EPC);
        chk(S_RDATA, "rdw_new", 32'h0000_1234);

        // trap overrides same-cycle mtc0 EPC
        next(); trap(EXC_SYSCALL, 32'h0040_0300); wr(REG_EPC, 32'h0000_DEAD);
        chk(S_TAKEN, "ovr_taken", 32'h1);
        next(); rd(REG_EPC);
        chk(S_RDATA, "ovr_epc", 32'h0040_0300);
        chk(S_STATUS, "ovr_status", 32'h0000_01E0);

        // mtc0 Cause only touches [6:2]
        next(); wr(REG_CAUSE, 32'hFFFF_FFFF);
        next(); rd(REG_CAUSE);
        chk(S_RDATA, "cause_wr", 32'h0000_007C);

        next(); wr(5'd5, 32'hA5A5_A5A5); bus.mfc0 = 1'b1;
        chk(S_RDATA, "unimpl_read", 32'h0);

        next(); bus.eret = 1'b1; bus.addr = REG_STATUS;
        chk(S_RDATA, "no_mfc0_read", 32'h0);
        chk(S_TAKEN, "eret2_taken", 32'h1);
        chk(S_EADDR, "eret2_eaddr", 32'h0040_0300);

        // timer: Count reaches Compare=5 five cycles after Compare is written
        next(); wr(REG_COUNT, 32'h0);
        chk(S_STATUS, "timer_status", 32'h0000_000F);
        next(); wr(REG_COMPARE, 32'd5);
        repeat (4) next();
        next();
        chk(S_TIRQ, "tirq_before", 32'h0);
        next(); rd(REG_CAUSE);
        chk(S_TIRQ, "tirq_set", 32'h1);
        chk(S_RDATA, "tirq_cause", 32'h0000_807C);
        next(); wr(REG_COMPARE, 32'd100);
        chk(S_TIRQ, "tirq_held", 32'h1);
        next(); rd(REG_CAUSE);
        chk(S_TIRQ, "tirq_clr", 32'h0);
        chk(S_RDATA, "tirq_clr_cause", 32'h0000_007C);

        // Count wrap
        next(); wr(REG_COUNT, 32'hFFFF_FFFF);
        next(); rd(REG_COUNT);
        chk(S_RDATA, "count_max", 32'hFFFF_FFFF);
        next(); rd(REG_COUNT);
        chk(S_RDATA, "count_wrap", 32'h0);

        // reset asserted during an accepted trap
        next(); trap(EXC_SYSCALL, 32'h0040_0500);
        chk(S_TAKEN, "midrst_taken", 32'h1);
        #6 rst_n = 1'b0;
        next(); trap(EXC_SYSCALL, 32'h0040_0500); rd(REG_EPC);
        chk(S_TAKEN, "midrst_taken_held", 32'h0);
        chk(S_STATUS, "midrst_status", 32'h0000_000F);
        chk(S_EADDR, "midrst_eaddr", EXC_VECTOR);
        chk(S_RDATA, "midrst_rdata", 32'h0);
        next(); rst_n = 1'b1; rd(REG_EPC);
        chk(S_RDATA, "postrst_epc", 32'h0);
        chk(S_STATUS, "postrst_status", 32'h0000_000F);
        next(); rd(REG_CAUSE);
        chk(S_RDATA, "postrst_cause", 32'h0);
        next(); rd(REG_COMPARE);
        chk(S_RDATA, "postrst_compare", 32'h0);

        next();
        next();
        n_checks++;
        if (tag_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", tag_q.size());
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
